// File: rtl/min_sum_pkg.sv
// Shared types and sizing helpers for the min-sum decoder controller and datapath.
package min_sum_pkg;

    localparam int unsigned MAX_ITER_DEF = 16;
    localparam int unsigned VN_CYC_DEF   = 2;
    localparam int unsigned CN_CYC_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        VN   = 3'd2,
        CN   = 3'd3,
        SYND = 3'd4,
        DONE = 3'd5
    } ctrl_state_e;

    function automatic int unsigned iter_w(input int unsigned max_iter);
        return $clog2(max_iter + 1);
    endfunction

    function automatic int unsigned phase_w(input int unsigned vn_cyc, input int unsigned cn_cyc);
        return $clog2(((vn_cyc > cn_cyc) ? vn_cyc : cn_cyc) + 1);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; done_c marks the last cycle of a loaded phase.
module phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt;

    // Stops at zero so an idle timer never wraps into a spurious done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c = (cnt == W'(1));

endmodule

// File: rtl/min_sum_iter_ctrl.sv
// Iteration sequencer for the min-sum decoder: load, VN/CN phases, optional syndrome stop.
// Early termination is built only when MIN_SUM_EARLY_TERM_EN is defined.
module min_sum_iter_ctrl
    import min_sum_pkg::*;
#(
    parameter int unsigned MAX_ITER = MAX_ITER_DEF,
    parameter int unsigned VN_CYC   = VN_CYC_DEF,
    parameter int unsigned CN_CYC   = CN_CYC_DEF,
    localparam int unsigned ITER_W  = iter_w(MAX_ITER)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ITER_W-1:0] iter_limit,
    output logic              llr_load,
    output logic              vn_en,
    output logic              cn_en,
    output logic              first_iter,
    output logic              synd_chk,
    input  logic              syndrome_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_count,
    output logic              converged
);

    localparam int unsigned PH_W = phase_w(VN_CYC, CN_CYC);

    ctrl_state_e       state_q, state_d;
    logic [ITER_W-1:0] lim_q, lim_d, lim_req_c, iter_d;
    logic              conv_d;
    logic              ph_load_c, ph_done_c;
    logic [PH_W-1:0]   ph_val_c;

`ifndef MIN_SUM_EARLY_TERM_EN
    logic unused_syndrome_ok;
    assign unused_syndrome_ok = syndrome_ok;
`endif

    phase_timer #(.W(PH_W)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load_c),
        .load_val (ph_val_c),
        .done_c   (ph_done_c)
    );

    // Requested limit clamped into [1, MAX_ITER].
    always_comb begin
        lim_req_c = (iter_limit == '0) ? ITER_W'(1) : iter_limit;
        if (lim_req_c > ITER_W'(MAX_ITER)) begin
            lim_req_c = ITER_W'(MAX_ITER);
        end
    end

    always_comb begin
        state_d   = state_q;
        lim_d     = lim_q;
        iter_d    = iter_count;
        conv_d    = converged;
        ph_load_c = 1'b0;
        ph_val_c  = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    lim_d   = lim_req_c;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = VN;
            VN: begin
                if (ph_done_c) state_d = CN;
            end
            CN: begin
                if (ph_done_c) begin
`ifdef MIN_SUM_EARLY_TERM_EN
                    state_d = SYND;
`else
                    iter_d  = iter_count + ITER_W'(1);
                    state_d = (iter_d == lim_q) ? DONE : VN;
`endif
                end
            end
`ifdef MIN_SUM_EARLY_TERM_EN
            SYND: begin
                iter_d = iter_count + ITER_W'(1);
                if (syndrome_ok) begin
                    conv_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = (iter_d == lim_q) ? DONE : VN;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timer reloads on every phase entry.
        if (state_d != state_q && state_d == VN) begin
            ph_load_c = 1'b1;
            ph_val_c  = PH_W'(VN_CYC);
        end else if (state_d != state_q && state_d == CN) begin
            ph_load_c = 1'b1;
            ph_val_c  = PH_W'(CN_CYC);
        end
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lim_q      <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            in_ready   <= 1'b1;
            llr_load   <= 1'b0;
            vn_en      <= 1'b0;
            cn_en      <= 1'b0;
            first_iter <= 1'b0;
            synd_chk   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lim_q      <= lim_d;
            iter_count <= iter_d;
            converged  <= conv_d;
            in_ready   <= (state_d == IDLE);
            llr_load   <= (state_d == LOAD);
            vn_en      <= (state_d == VN);
            cn_en      <= (state_d == CN);
            first_iter <= (state_d == VN) && (iter_d == '0);
`ifdef MIN_SUM_EARLY_TERM_EN
            synd_chk   <= (state_d == SYND);
`else
            synd_chk   <= 1'b0;
`endif
            out_valid  <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_min_sum_iter_ctrl.sv
// Scoreboard bench for min_sum_iter_ctrl; expectations follow MIN_SUM_EARLY_TERM_EN.
`timescale 1ns/1ps
module tb_min_sum_iter_ctrl;
    import min_sum_pkg::*;

    localparam int unsigned ITER_W = iter_w(MAX_ITER_DEF);
`ifdef MIN_SUM_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ITER_W-1:0] iter_limit = '0;
    logic              llr_load, vn_en, cn_en, first_iter, synd_chk;
    logic              syndrome_ok = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ITER_W-1:0] iter_count;
    logic              converged;

    min_sum_iter_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .iter_limit(iter_limit), .llr_load(llr_load), .vn_en(vn_en), .cn_en(cn_en),
        .first_iter(first_iter), .synd_chk(synd_chk), .syndrome_ok(syndrome_ok),
        .out_valid(out_valid), .out_ready(out_ready), .iter_count(iter_count),
        .converged(converged)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int it;
        int cv;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   vn_cnt = 0, first_cnt = 0, first_bad = 0, synd_cnt = 0;
    int   synd_seen = 0, ok_at = 0;
    bit   ok_always = 1'b0;
    bit   ov_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Activity counters and syndrome responder.
    always @(negedge clk) begin
        if (vn_en) vn_cnt++;
        if (vn_en && first_iter) first_cnt++;
        if (first_iter && !vn_en) first_bad++;
        if (synd_chk) begin
            synd_cnt++;
            synd_seen++;
        end
        syndrome_ok = ok_always || (synd_chk && synd_seen == ok_at);
    end

    // Monitor: compare each new result against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", cyc - e.acc, e.lat);
                chk("iter_count", int'(iter_count), e.it);
                chk("converged", int'(converged), e.cv);
            end
        end
        ov_prev = out_valid;
    end

    task automatic send(input int lim, input int ok_idx, input bit ok_all,
                        input int lat, input int it, input int cv);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        ok_at     = ok_idx;
        ok_always = ok_all;
        synd_seen = 0;
        vn_cnt = 0; first_cnt = 0; first_bad = 0; synd_cnt = 0;
        in_valid   = 1'b1;
        iter_limit = ITER_W'(lim);
        @(negedge clk);
        chk("accept_llr_load", int'(llr_load), 1);
        e.lat = lat; e.it = it; e.cv = cv; e.acc = cyc;
        exp_q.push_back(e);
        in_valid   = 1'b0;
        iter_limit = ITER_W'(7);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic chk_idle_outs(input string name);
        chk({name, "_in_ready"}, int'(in_ready), 1);
        chk({name, "_strobes"}, int'({llr_load, vn_en, cn_en, first_iter, synd_chk, out_valid}), 0);
        chk({name, "_iter"}, int'(iter_count), 0);
        chk({name, "_conv"}, int'(converged), 0);
    endtask

    initial begin
        int n;
        exp_t e;
        repeat (2) @(negedge clk);
        chk_idle_outs("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outs("post_reset");

        // Full run, no convergence.
        send(3, 0, 1'b0, ET ? 16 : 13, 3, 0);
        wait_done("t1");
        chk("t1_vn_cycles", vn_cnt, 6);
        chk("t1_first_iter_cycles", first_cnt, 2);
        chk("t1_first_iter_outside_vn", first_bad, 0);
        chk("t1_synd_chk_cycles", synd_cnt, ET ? 3 : 0);

        // Converges on the second syndrome check.
        send(5, 2, 1'b0, ET ? 11 : 21, ET ? 2 : 5, ET ? 1 : 0);
        wait_done("t2");

        // Zero limit behaves as one.
        send(0, 0, 1'b0, ET ? 6 : 5, 1, 0);
        wait_done("t3");

        // Over-range limit saturates at MAX_ITER.
        send(20, 0, 1'b0, ET ? 81 : 65, 16, 0);
        wait_done("t4");

        // Back-pressure in DONE with in_valid held.
        out_ready = 1'b0;
        send(1, 0, 1'b0, ET ? 6 : 5, 1, 0);
        in_valid   = 1'b1;
        iter_limit = ITER_W'(2);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("t5_out_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", int'(out_valid), 1);
            chk("t5_hold_in_ready", int'(in_ready), 0);
            chk("t5_hold_iter", int'(iter_count), 1);
            chk("t5_hold_conv", int'(converged), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_idle_in_ready", int'(in_ready), 1);
        chk("t5_idle_out_valid", int'(out_valid), 0);
        chk("t5_no_early_accept", int'(llr_load), 0);
        @(negedge clk);
        chk("t5_accept_after_handshake", int'(llr_load), 1);
        e.lat = ET ? 11 : 9; e.it = 2; e.cv = 0; e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        wait_done("t5");

        // Asynchronous reset in the second CN phase, then a clean frame.
        send(3, 0, 1'b0, 0, 0, 0);
        n = 0;
        while (!(cn_en && iter_count == ITER_W'(1)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_cn", int'(cn_en), 1);
        rst = 1'b0;
        #1;
        chk_idle_outs("t6_mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        send(2, 0, 1'b0, ET ? 11 : 9, 2, 0);
        wait_done("t6");

        // syndrome_ok held high throughout.
        send(3, 0, 1'b1, ET ? 6 : 13, ET ? 1 : 3, ET ? 1 : 0);
        wait_done("t7");
        chk("t7_synd_chk_cycles", synd_cnt, ET ? 1 : 0);
        ok_always = 1'b0;

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/min_sum_iter_ctrl.md
Name: min_sum_iter_ctrl

Overview:
- Sequencing FSM for the iterative min-sum decoder.
- Accepts one LLR frame per handshake, then alternates variable-node and check-node layer phases.
- Optionally checks the syndrome after each iteration and stops early on success.
- Returns a result handshake with iteration count and convergence flag.
- Sits between the frame input buffer and the variable_nodes / check-node datapath; drives their load/enable strobes only, never message data.

Parameters:
- MAX_ITER, 16: maximum supported iteration count; sets ITER_W = $clog2(MAX_ITER+1).
- VN_CYC, 2: cycles the vn_en strobe stays asserted per iteration (datapath settle/pipeline depth); must be ≥ 1.
- CN_CYC, 2: cycles the cn_en strobe stays asserted per iteration; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  LLR frame present at decoder input.
- in_ready  out  1  controller can accept a frame.
- iter_limit  in  ITER_W  requested iterations; sampled on accept.
- llr_load  out  1  datapath captures LLRs and clears messages.
- vn_en  out  1  variable-node layer update enable.
- cn_en  out  1  check-node layer update enable.
- first_iter  out  1  vn phase uses zero prior messages (iteration 0).
- synd_chk  out  1  syndrome sample strobe.
- syndrome_ok  in  1  all parity checks satisfied on current hard decisions.
- out_valid  out  1  decoded frame and status valid.
- out_ready  in  1  downstream consumes result.
- iter_count  out  ITER_W  completed iterations for the current/last frame.
- converged  out  1  frame ended on zero syndrome.

Behaviour:
- Reset (async, any state, including mid-phase): state=IDLE; phase counter=0; iter_count=0; converged=0.
- Reset output values: in_ready=1; all other outputs 0.
- All outputs are Moore outputs (registered state decode); no combinational path from any input to any output.
- States: IDLE, LOAD, VN, CN, SYND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch lim = max(iter_limit,1), saturated to MAX_ITER; clear iter_count and converged; go to LOAD.
- LOAD: exactly 1 cycle, llr_load=1; then go to VN.
- VN:
  - vn_en=1 for exactly VN_CYC cycles.
  - first_iter=1 throughout when iter_count==0.
  - Then go to CN.
- CN: cn_en=1 for exactly CN_CYC cycles; then go to SYND (with macro) or to the iteration-end decision (without macro).
- SYND: 1 cycle, synd_chk=1; syndrome_ok is sampled on this cycle's closing edge.
- Iteration end:
  - iter_count += 1.
  - If syndrome_ok (macro only): converged=1, go to DONE.
  - Else if the new iter_count == lim: go to DONE.
  - Else go to VN.
- DONE:
  - out_valid=1; iter_count and converged held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 until IDLE is re-entered, so no overlap of frames.
- in_valid is ignored outside IDLE.
- Inputs iter_limit/in_valid changing mid-frame have no effect.
- Latency, accept edge to first out_valid cycle:
  - 1 + n·(VN_CYC+CN_CYC+1) with macro, where n = iterations run.
  - 1 + lim·(VN_CYC+CN_CYC) without macro.
- Phase counter is ITER-independent, width $clog2(max(VN_CYC,CN_CYC)+1); it reloads on every phase entry and never wraps.
- iter_count never exceeds MAX_ITER.

Optional Feature:
- MIN_SUM_EARLY_TERM_EN defined: SYND state present; syndrome_ok honoured; converged can be 1.
- Undefined: SYND state removed; synd_chk tied 0; syndrome_ok ignored; converged tied 0; every frame runs exactly lim iterations.

Decomposition:
- Package min_sum_pkg contains:
  - the ctrl_state_e enum (IDLE, LOAD, VN, CN, SYND, DONE);
  - the ITER_W function/localparam helper;
  - default VN_CYC/CN_CYC constants shared with the datapath.
- Sub-module phase_timer: loadable down-counter with a done pulse, used for the VN and CN phase lengths.

Test Plan (VN_CYC=2, CN_CYC=2 unless noted):
- Macro on, iter_limit=3, syndrome_ok=0 → out_valid 16 cycles after accept; iter_count=3; converged=0; vn_en asserted 6 cycles total; first_iter asserted only on the first 2.
- Macro on, iter_limit=5, syndrome_ok=1 only at the 2nd SYND → out_valid at cycle 11; iter_count=2; converged=1.
- iter_limit=0 → treated as 1; out_valid at cycle 6; iter_count=1.
- Back-pressure:
  - Stimulus: out_ready low for 5 cycles in DONE, in_valid held high.
  - Required: out_valid, iter_count and converged stable; in_ready=0; new frame accepted only on the cycle after the out_ready handshake.
- rst asserted mid-CN → next edge sees all outputs 0 and in_ready=1; the following frame decodes with normal latency.
- Macro off, iter_limit=3, syndrome_ok=1 always → out_valid at cycle 13; converged=0; synd_chk never asserted.
